// File: rtl/gate_sweep_ctrl.sv
// gate_sweep_ctrl
//
// Stimulus sequencer and checker for a 2-input combinational gate.
// A start request walks the gate inputs through 00, 01, 10, 11, holding
// each vector for HOLD_CYCLES cycles. At the end of each hold the gate
// output is compared against TRUTH. The result is reported through a
// start/busy/done handshake.
//
// Parameters
//   HOLD_CYCLES  cycles each vector is held before sampling (1..255)
//   TRUTH        expected gate output indexed by {gate_a, gate_b}
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   start      sweep request, ignored while busy
//   gate_a/b   gate-under-test inputs
//   gate_c     gate-under-test output, sampled raw (synchronize externally)
//   busy       sweep in progress
//   done       one-cycle pulse at end of sweep
//   pass       last completed sweep had no mismatches
//   err_cnt    mismatch count of current/last sweep (0..4)
//   fail_vec   {a,b} of first mismatching vector
//
// Build option
//   GATE_SWEEP_CAPTURE_EN  when defined, fail_vec captures the first
//                          mismatching vector; otherwise it is tied to 0.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | gate inputs parked at 00, waiting for start
// ST_DRIVE | driving vector vec_q, hold timer running down to sample

module gate_sweep_ctrl #(
   parameter int         HOLD_CYCLES = 5,
   parameter logic [3:0] TRUTH       = 4'b1000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   output logic       gate_a,
   output logic       gate_b,
   input  logic       gate_c,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [2:0] err_cnt,
   output logic [1:0] fail_vec
);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_DRIVE = 1'b1
   } state_t;

   // Hold timer runs down from HOLD_CYCLES-1; zero marks the sample edge.
   localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

   state_t     state_q, state_d;
   logic [1:0] vec_q,   vec_d;
   logic [7:0] cnt_q,   cnt_d;
   logic [2:0] err_q,   err_d;
   logic       pass_q,  pass_d;
   logic       done_q,  done_d;

   logic accept;
   logic sample_edge;
   logic miss;

   assign accept      = (state_q == ST_IDLE) && start;
   assign sample_edge = (state_q == ST_DRIVE) && (cnt_q == 8'd0);
   assign miss        = sample_edge && (gate_c != TRUTH[vec_q]);

   always_comb begin
      state_d = state_q;
      vec_d   = vec_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      pass_d  = pass_q;
      done_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d = ST_DRIVE;
               vec_d   = 2'd0;
               cnt_d   = HOLD_LAST;
               err_d   = 3'd0;
               pass_d  = 1'b0;
            end
         end
         ST_DRIVE: begin
            if (sample_edge) begin
               cnt_d = HOLD_LAST;
               if (miss && (err_q != 3'd4)) begin
                  err_d = err_q + 3'd1;
               end
               if (vec_q == 2'd3) begin
                  state_d = ST_IDLE;
                  vec_d   = 2'd0;
                  done_d  = 1'b1;
                  // err_q does not yet include the final sample.
                  pass_d  = (err_q == 3'd0) && !miss;
               end else begin
                  vec_d = vec_q + 2'd1;
               end
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         vec_q   <= 2'd0;
         cnt_q   <= 8'd0;
         err_q   <= 3'd0;
         pass_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         vec_q   <= vec_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         pass_q  <= pass_d;
         done_q  <= done_d;
      end
   end

   assign busy    = (state_q == ST_DRIVE);
   assign gate_a  = busy & vec_q[1];
   assign gate_b  = busy & vec_q[0];
   assign done    = done_q;
   assign pass    = pass_q;
   assign err_cnt = err_q;

`ifdef GATE_SWEEP_CAPTURE_EN
   logic [1:0] fail_q, fail_d;

   // First mismatch of a sweep is the one seen while err_q is still zero.
   always_comb begin
      fail_d = fail_q;
      if (accept) begin
         fail_d = 2'b00;
      end else if (miss && (err_q == 3'd0)) begin
         fail_d = vec_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fail_q <= 2'b00;
      end else begin
         fail_q <= fail_d;
      end
   end

   assign fail_vec = fail_q;
`else
   assign fail_vec = 2'b00;
`endif

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
`timescale 1ns/1ps

module tb_gate_sweep_ctrl;

`ifdef GATE_SWEEP_CAPTURE_EN
   localparam bit CAP = 1'b1;
`else
   localparam bit CAP = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       start_s [2];
   logic [3:0] tab_s   [2];

   logic       ga0, gb0, gc0, busy0, done0, pass0;
   logic [2:0] err0;
   logic [1:0] fv0;
   logic       ga1, gb1, gc1, busy1, done1, pass1;
   logic [2:0] err1;
   logic [1:0] fv1;

   logic [9:0] obs [2];

   int ncmp = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   // Behavioural gates under test: output looked up from a per-sweep table.
   assign gc0 = tab_s[0][{ga0, gb0}];
   assign gc1 = tab_s[1][{ga1, gb1}];

   assign obs[0] = {busy0, done0, ga0, gb0, pass0, err0, fv0};
   assign obs[1] = {busy1, done1, ga1, gb1, pass1, err1, fv1};

   gate_sweep_ctrl #(.HOLD_CYCLES(5), .TRUTH(4'b1000)) dut (
      .clk(clk), .rst(rst), .start(start_s[0]),
      .gate_a(ga0), .gate_b(gb0), .gate_c(gc0),
      .busy(busy0), .done(done0), .pass(pass0),
      .err_cnt(err0), .fail_vec(fv0)
   );

   gate_sweep_ctrl #(.HOLD_CYCLES(1), .TRUTH(4'b0110)) dut_x (
      .clk(clk), .rst(rst), .start(start_s[1]),
      .gate_a(ga1), .gate_b(gb1), .gate_c(gc1),
      .busy(busy1), .done(done1), .pass(pass1),
      .err_cnt(err1), .fail_vec(fv1)
   );

   typedef struct {
      int         sel;
      logic [3:0] tab;
      bit         noise;
      logic [2:0] err;
      bit         pass;
      logic [1:0] fail;
      string      nm;
   } vec_t;

   vec_t tbl [10];

   function automatic logic [9:0] pk(input bit b, input bit d, input logic [1:0] v,
                                     input bit p, input logic [2:0] e, input logic [1:0] f);
      return {b, d, v, p, e, f};
   endfunction

   // Number of mismatching vectors among indices 0..upto-1.
   function automatic logic [2:0] n_miss(input logic [3:0] m, input int upto);
      logic [2:0] c;
      c = 3'd0;
      for (int i = 0; i < upto; i++) if (m[i]) c = c + 3'd1;
      return c;
   endfunction

   // Index of the first mismatch among 0..upto-1, or 0 if none.
   function automatic logic [1:0] first_miss(input logic [3:0] m, input int upto);
      logic [1:0] r;
      bit         found;
      r = 2'd0;
      found = 1'b0;
      for (int i = 0; i < upto; i++) begin
         if (m[i] && !found) begin
            r = 2'(i);
            found = 1'b1;
         end
      end
      return r;
   endfunction

   task automatic chk(input string nm, input logic [9:0] act, input logic [9:0] exp);
      ncmp++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s t=%0t busy,done,ab,pass,err,fv got %b expected %b", nm, $time, act, exp);
      end
   endtask

   // Assumes the caller has just left a negedge. Next posedge is E0 (start
   // must be high for it). Checks every cycle of the sweep and the done cycle.
   // With hold set, start stays high and the task returns in the done cycle.
   task automatic sweep_body(input int sel, input logic [3:0] tab, input bit hold,
                             input bit noise, input logic [2:0] x_err,
                             input bit x_pass, input logic [1:0] x_fail, input string nm);
      int         h;
      int         k;
      logic [3:0] tr;
      logic [3:0] mis;
      logic [1:0] fexp;
      h   = (sel == 1) ? 1 : 5;
      tr  = (sel == 1) ? 4'b0110 : 4'b1000;
      mis = tab ^ tr;
      tab_s[sel] = tab;
      @(posedge clk);
      for (int t = 1; t <= 4 * h; t++) begin
         @(negedge clk);
         k = (t - 1) / h;
         fexp = CAP ? first_miss(mis, k) : 2'b00;
         chk({nm, "_busy"}, obs[sel], pk(1'b1, 1'b0, 2'(k), 1'b0, n_miss(mis, k), fexp));
         start_s[sel] = hold ? 1'b1 : (noise ? 1'($urandom_range(0, 1)) : 1'b0);
      end
      @(negedge clk);
      fexp = CAP ? x_fail : 2'b00;
      chk({nm, "_done"}, obs[sel], pk(1'b0, 1'b1, 2'b00, x_pass, x_err, fexp));
      start_s[sel] = hold;
      if (!hold) begin
         @(negedge clk);
         chk({nm, "_after"}, obs[sel], pk(1'b0, 1'b0, 2'b00, x_pass, x_err, fexp));
      end
   endtask

   task automatic sweep(input int sel, input logic [3:0] tab, input bit hold,
                        input bit noise, input logic [2:0] x_err,
                        input bit x_pass, input logic [1:0] x_fail, input string nm);
      start_s[sel] = 1'b1;
      sweep_body(sel, tab, hold, noise, x_err, x_pass, x_fail, nm);
   endtask

   initial begin
      int         sel;
      logic [3:0] tab;
      logic [3:0] mis;

      tbl[0] = '{0, 4'b1000, 0, 3'd0, 1, 2'b00, "and_ok"};
      tbl[1] = '{0, 4'b0000, 0, 3'd1, 0, 2'b11, "stuck0"};
      tbl[2] = '{0, 4'b1111, 1, 3'd3, 0, 2'b00, "stuck1"};
      tbl[3] = '{0, 4'b0110, 1, 3'd3, 0, 2'b01, "xor_on_and"};
      tbl[4] = '{0, 4'b1110, 0, 3'd2, 0, 2'b01, "or_on_and"};
      tbl[5] = '{0, 4'b0111, 1, 3'd4, 0, 2'b00, "nand_on_and"};
      tbl[6] = '{0, 4'b0100, 0, 3'd2, 0, 2'b10, "a_nb_on_and"};
      tbl[7] = '{1, 4'b0110, 0, 3'd0, 1, 2'b00, "xor_ok_h1"};
      tbl[8] = '{1, 4'b1001, 1, 3'd4, 0, 2'b00, "xnor_h1"};
      tbl[9] = '{1, 4'b1000, 0, 3'd3, 0, 2'b01, "and_on_xor_h1"};

      rst = 1'b1;
      start_s[0] = 1'b0;
      start_s[1] = 1'b0;
      tab_s[0] = 4'b1000;
      tab_s[1] = 4'b0110;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset0", obs[0], 10'd0);
      chk("reset1", obs[1], 10'd0);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 10; i++) begin
         sweep(tbl[i].sel, tbl[i].tab, 1'b0, tbl[i].noise, tbl[i].err,
               tbl[i].pass, tbl[i].fail, tbl[i].nm);
      end

      // Back-to-back: start held through the sweep and into the done cycle.
      sweep(0, 4'b0000, 1'b1, 1'b0, 3'd1, 1'b0, 2'b11, "b2b_first");
      sweep_body(0, 4'b1000, 1'b0, 1'b0, 3'd0, 1'b1, 2'b00, "b2b_second");

      // Reset in the middle of vector 01.
      tab_s[0] = 4'b1111;
      start_s[0] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start_s[0] = 1'b0;
      repeat (6) @(negedge clk);
      chk("pre_rst", obs[0], pk(1'b1, 1'b0, 2'b01, 1'b0, 3'd1, 2'b00));
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst", obs[0], 10'd0);
      rst = 1'b0;
      for (int t = 0; t < 25; t++) begin
         @(negedge clk);
         chk("post_rst_quiet", obs[0], 10'd0);
      end
      sweep(0, 4'b1000, 1'b0, 1'b0, 3'd0, 1'b1, 2'b00, "after_rst");

      // Random gates against the reference model.
      for (int i = 0; i < 40; i++) begin
         sel = int'($urandom_range(0, 1));
         tab = 4'($urandom);
         mis = tab ^ ((sel == 1) ? 4'b0110 : 4'b1000);
         repeat ($urandom_range(0, 3)) @(negedge clk);
         sweep(sel, tab, 1'b0, 1'b1, n_miss(mis, 4), (mis == 4'd0),
               first_miss(mis, 4), "rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule
